// File: rtl/serdes_pkg.sv
// +----------------------------------------------------------------------+
// | serdes_pkg : shared widths, line levels and FSM encoding (rev 1.0)   |
// +----------------------------------------------------------------------+
`default_nettype none

package serdes_pkg;

  localparam int   SERDES_WIDTH       = 8;
  localparam int   FRAME_LEN          = SERDES_WIDTH + 1;
  localparam logic SERDES_START_LEVEL = 1'b1;
  localparam logic SERDES_IDLE_LEVEL  = 1'b0;

  // Bit counter width; never below one bit so WIDTH=1 still elaborates.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int SERDES_CNT_W = cnt_width(SERDES_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2
  } ser_state_e;

endpackage

`default_nettype wire

// File: rtl/serdes_hold_reg.sv
// +----------------------------------------------------------------------+
// | serdes_hold_reg : one-entry valid/ready holding buffer (rev 1.0)     |
// +----------------------------------------------------------------------+
`default_nettype none

module serdes_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic             rd_take_i,
  output logic             rd_full_o,
  output logic [WIDTH-1:0] rd_data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // No bypass: a full buffer refuses a word even on the edge it drains.
  assign wr_ready_o = ~full_q;
  assign load       = wr_valid_i & ~full_q;
  assign rd_full_o  = full_q;
  assign rd_data_o  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end else if (rd_take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serializador.sv
// +----------------------------------------------------------------------+
// | serializador : parallel word to start-bit + MSB-first serial frame   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module serializador
  import serdes_pkg::*;
#(
  parameter int   WIDTH       = SERDES_WIDTH,
  parameter logic START_LEVEL = SERDES_START_LEVEL,
  parameter logic IDLE_LEVEL  = SERDES_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CNT_W = cnt_width(WIDTH);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             take;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  serdes_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .wr_data_i  (data_in),
    .wr_valid_i (data_valid),
    .wr_ready_o (data_ready),
    .rd_take_i  (take),
    .rd_full_o  (hold_full),
    .rd_data_o  (hold_data)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = IDLE_LEVEL;
        if (hold_full) begin
          shift_d = hold_data;
          take    = 1'b1;
          out_d   = START_LEVEL;
          state_d = START;
        end
      end
      START: begin
        out_d   = shift_q[WIDTH-1];
        shift_d = shift_q << 1;
        cnt_d   = CNT_W'(WIDTH - 1);
        done_d  = (WIDTH == 1);
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q != '0) begin
          out_d   = shift_q[WIDTH-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - 1'b1;
          done_d  = (cnt_q == CNT_W'(1));
        end else if (hold_full) begin
          // Reload straight into a new start bit: no idle gap between frames.
          shift_d = hold_data;
          take    = 1'b1;
          out_d   = START_LEVEL;
          state_d = START;
        end else begin
          out_d   = IDLE_LEVEL;
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out        = out_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire
